fire_expand_scheduler: RTL

Sequencer and arbiter for the shared fire2/fire3 expand-1x1 engine. Grants the engine to one fire layer at a time and drives it per output pixel: input-feature-map read addresses, MAC enable, per-pixel accumulator sample/clear pulse, OFM write strobe/address and per-layer finish pulses. Sits between the squeeze-output RAMs and the 64-DSP expand datapath.

---
 rtl/fire_sched_pkg.sv | 8 +
 rtl/fire_sched_addr_gen.sv | 38 +++
 rtl/fire_expand_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/fire_sched_pkg.sv
// fire_sched_pkg: shared state/layer types and default sizes for the fire expand scheduler
package fire_sched_pkg;
  typedef enum logic [2:0] {IDLE, ARB, RUN, DRAIN, WRITE, DONE} state_t;
  typedef enum logic {FIRE2, FIRE3} layer_t;
  localparam int WOUT_DEF = 64;
  localparam int CHIN_DEF = 16;
  localparam int DSP_NO_DEF = 64;
endpackage

// File: rtl/fire_sched_addr_gen.sv
// fire_sched_addr_gen: pixel/channel counters and ifm/ofm address generation
module fire_sched_addr_gen
  import fire_sched_pkg::*;
#(
  parameter int WOUT = WOUT_DEF,
  parameter int CHIN = CHIN_DEF,
  parameter int IA_W = $clog2(WOUT * WOUT * CHIN),
  parameter int OA_W = $clog2(WOUT * WOUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc_c,
  input  logic            inc_p,
  output logic [IA_W-1:0] ifm_addr,
  output logic [OA_W-1:0] ofm_addr,
  output logic            last_c,
  output logic            last_p
);
  localparam int CW = CHIN > 1 ? $clog2(CHIN) : 1;
  localparam int NPIX = WOUT * WOUT;
  logic [CW-1:0] c;
  logic [OA_W-1:0] p;
  assign last_c = c == CW'(CHIN - 1);
  assign last_p = p == OA_W'(NPIX - 1);
  assign ifm_addr = IA_W'(p) * IA_W'(CHIN) + IA_W'(c);
  assign ofm_addr = p;
  // channel counter wraps on the last read so the next pixel starts at channel 0
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      c <= '0;
      p <= '0;
    end else begin
      if (inc_c) c <= last_c ? '0 : c + 1'b1;
      if (inc_p) p <= p + 1'b1;
    end
  end
endmodule

// File: rtl/fire_expand_scheduler.sv
// fire_expand_scheduler: fire2/fire3 expand-1x1 arbiter and per-pixel sequencer; FIRE_SCHED_STATS_EN adds run/stall counters
module fire_expand_scheduler
  import fire_sched_pkg::*;
#(
  parameter int WOUT   = WOUT_DEF,
  parameter int CHIN   = CHIN_DEF,
  parameter int DSP_NO = DSP_NO_DEF,
  parameter int IA_W   = $clog2(WOUT * WOUT * CHIN),
  parameter int OA_W   = $clog2(WOUT * WOUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_2,
  input  logic            req_3,
  input  logic            ifm_valid,
  input  logic            ofm_ready,
  output logic            grant_2,
  output logic            grant_3,
  output logic [IA_W-1:0] ifm_addr,
  output logic            mac_en,
  output logic            sample,
  output logic            ofm_we,
  output logic [OA_W-1:0] ofm_addr,
  output logic            finish_2,
  output logic            finish_3,
  output logic            busy
`ifdef FIRE_SCHED_STATS_EN
  ,
  output logic [31:0]     run_cycles,
  output logic [31:0]     stall_cycles
`endif
);
  if (DSP_NO < 1) begin : g_bad_dsp
    $error("DSP_NO must be positive");
  end
  state_t state;
  layer_t layer;
  logic last_c, last_p;
  assign busy = state != IDLE;
  assign grant_2 = busy && layer == FIRE2;
  assign grant_3 = busy && layer == FIRE3;
  assign ofm_we = state == WRITE;
  assign finish_2 = state == DONE && layer == FIRE2;
  assign finish_3 = state == DONE && layer == FIRE3;
  fire_sched_addr_gen #(.WOUT(WOUT), .CHIN(CHIN), .IA_W(IA_W), .OA_W(OA_W)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ARB || state == DONE),
    .inc_c   (state == RUN && ifm_valid),
    .inc_p   (state == WRITE && ofm_ready && !last_p),
    .ifm_addr(ifm_addr),
    .ofm_addr(ofm_addr),
    .last_c  (last_c),
    .last_p  (last_p)
  );
  // layer is chosen as the engine leaves IDLE so the grant is already visible during ARB
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      layer  <= FIRE2;
      mac_en <= 1'b0;
      sample <= 1'b0;
    end else begin
      mac_en <= state == RUN && ifm_valid;
      sample <= state == DRAIN;
      case (state)
        IDLE: if (req_2 || req_3) begin
          state <= ARB;
          layer <= req_2 ? FIRE2 : FIRE3;
        end
        ARB:   state <= RUN;
        RUN:   if (ifm_valid && last_c) state <= DRAIN;
        DRAIN: state <= WRITE;
        WRITE: if (ofm_ready) state <= last_p ? DONE : RUN;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FIRE_SCHED_STATS_EN
  logic stall_now;
  assign stall_now = (state == RUN && !ifm_valid) || (state == WRITE && !ofm_ready);
  // run_cycles spans the request cycle through DONE, i.e. the full layer latency
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cycles   <= '0;
      stall_cycles <= '0;
    end else if (state == IDLE && (req_2 || req_3)) begin
      run_cycles   <= 32'd1;
      stall_cycles <= '0;
    end else if (busy) begin
      run_cycles   <= run_cycles + 32'd1;
      stall_cycles <= stall_cycles + 32'(stall_now);
    end
  end
`endif
endmodule
